// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: op encodings, datapath widths and the EX/MEM
// record used by the execute, memory and writeback stages.
package pipe_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int REG_W  = 3;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_ALU   = 2'd1,
        OP_LOAD  = 2'd2,
        OP_STORE = 2'd3
    } op_e;

    typedef struct packed {
        op_e               op;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] store_data;
        logic [REG_W-1:0]  rd;
    } ex_mem_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data memory port: one write port and one combinational read port.
interface mem_access_stage_if #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int ADDR_W = pipe_pkg::ADDR_W
);
    logic              wt_en;
    logic [ADDR_W-1:0] wt_addr;
    logic [DATA_W-1:0] data_wt;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] read_out;

    modport master (output wt_en, wt_addr, data_wt, rd_addr, input read_out);
    modport slave  (input wt_en, wt_addr, data_wt, rd_addr, output read_out);
endinterface

// File: rtl/pipe_reg.sv
// Pipeline register with valid bit: stall holds, flush clears valid (flush wins).
// The payload only loads alongside a valid op, so bubbles leave it unchanged.
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    input  logic         valid_in,
    input  logic [W-1:0] data_in,
    output logic         valid_q,
    output logic [W-1:0] data_q
);
    logic         valid_d;
    logic [W-1:0] data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d = valid_in;
            if (valid_in) data_d = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/mem_access_stage.sv
// Pipeline stage 3: EX/MEM register, data memory master, MEM/WB register,
// address fault flag and load/store event counters.
module mem_access_stage #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int ADDR_W = pipe_pkg::ADDR_W,
    parameter int REG_W  = pipe_pkg::REG_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [1:0]        ex_op,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_rd,
    output logic              ex_ready,
    input  logic              flush,
    input  logic              wb_stall,
    mem_access_stage_if.master mem,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              fault,
    output logic [CNT_W-1:0]  load_cnt,
    output logic [CNT_W-1:0]  store_cnt
);
    localparam int EXM_W = 2 + 2 * DATA_W + REG_W;
    localparam int WB_W  = 1 + REG_W + DATA_W;

    logic              exm_valid;
    logic [EXM_W-1:0]  exm_data;
    logic [1:0]        exm_op;
    logic [DATA_W-1:0] exm_result;
    logic [DATA_W-1:0] exm_sd;
    logic [REG_W-1:0]  exm_rd;

    logic              addr_bad, is_alu, is_load, is_store, retire;
    logic              wb_we_in, wb_we_raw;
    logic [DATA_W-1:0] wb_data_in;
    logic [WB_W-1:0]   wb_pay;

    logic              fault_q, fault_d;
    logic [CNT_W-1:0]  load_cnt_q, load_cnt_d, store_cnt_q, store_cnt_d;

    assign ex_ready = !wb_stall;

    pipe_reg #(.W(EXM_W)) u_ex_mem (
        .clk      (clk),
        .rst      (rst),
        .stall    (wb_stall),
        .flush    (flush),
        .valid_in (ex_valid && (ex_op != pipe_pkg::OP_NOP)),
        .data_in  ({ex_op, ex_result, ex_store_data, ex_rd}),
        .valid_q  (exm_valid),
        .data_q   (exm_data)
    );

    assign {exm_op, exm_result, exm_sd, exm_rd} = exm_data;

    assign addr_bad = |exm_result[DATA_W-1:ADDR_W];
    assign is_alu   = (exm_op == pipe_pkg::OP_ALU);
    assign is_load  = (exm_op == pipe_pkg::OP_LOAD);
    assign is_store = (exm_op == pipe_pkg::OP_STORE);
    assign retire   = exm_valid && !wb_stall && !flush;

    // rst gates the write so a store caught by reset never reaches memory
    assign mem.wt_en   = retire && is_store && !addr_bad && !rst;
    assign mem.wt_addr = exm_result[ADDR_W-1:0];
    assign mem.rd_addr = exm_result[ADDR_W-1:0];
    assign mem.data_wt = exm_sd;

    assign wb_we_in   = is_alu || (is_load && !addr_bad);
    assign wb_data_in = is_load ? (addr_bad ? '0 : mem.read_out) : exm_result;

    pipe_reg #(.W(WB_W)) u_mem_wb (
        .clk      (clk),
        .rst      (rst),
        .stall    (wb_stall),
        .flush    (1'b0),
        .valid_in (retire),
        .data_in  ({wb_we_in, exm_rd, wb_data_in}),
        .valid_q  (wb_valid),
        .data_q   (wb_pay)
    );

    assign {wb_we_raw, wb_rd, wb_data} = wb_pay;
    assign wb_we = wb_valid && wb_we_raw;

    always_comb begin
        fault_d     = fault_q;
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;
        if (retire && (is_load || is_store)) begin
            if (addr_bad)     fault_d     = 1'b1;
            else if (is_load) load_cnt_d  = load_cnt_q + CNT_W'(1);
            else              store_cnt_d = store_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q     <= 1'b0;
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else begin
            fault_q     <= fault_d;
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    assign fault     = fault_q;
    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a 256-word behavioural data memory.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_clr;
    logic        ex_valid;
    logic [1:0]  ex_op;
    logic [15:0] ex_result;
    logic [15:0] ex_store_data;
    logic [2:0]  ex_rd;
    logic        ex_ready;
    logic        flush;
    logic        wb_stall;
    logic        wb_valid;
    logic        wb_we;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        fault;
    logic [15:0] load_cnt;
    logic [15:0] store_cnt;

    logic [15:0] mem [256];
    int          wr_pulses = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          p;

    mem_access_stage_if mif ();

    mem_access_stage dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_op         (ex_op),
        .ex_result     (ex_result),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_ready      (ex_ready),
        .flush         (flush),
        .wb_stall      (wb_stall),
        .mem           (mif),
        .wb_valid      (wb_valid),
        .wb_we         (wb_we),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .fault         (fault),
        .load_cnt      (load_cnt),
        .store_cnt     (store_cnt)
    );

    always #5 clk = ~clk;

    assign mif.read_out = mem[mif.rd_addr];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
        end else if (mif.wt_en) begin
            mem[mif.wt_addr] <= mif.data_wt;
            wr_pulses <= wr_pulses + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] res,
                         input logic [15:0] sd, input logic [2:0] rd);
        ex_valid      = v;
        ex_op         = op;
        ex_result     = res;
        ex_store_data = sd;
        ex_rd         = rd;
    endtask

    task automatic nop();
        drive(1'b0, 2'd0, 16'h0000, 16'h0000, 3'd0);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; mem_clr = 1'b1; flush = 1'b0; wb_stall = 1'b0;
        nop();
        tick(); tick();
        rst = 1'b0; mem_clr = 1'b0;

        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_we", wb_we, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_fault", fault, 0);
        check("rst_load_cnt", load_cnt, 0);
        check("rst_store_cnt", store_cnt, 0);
        check("rst_wt_en", mif.wt_en, 0);
        check("rst_wt_addr", mif.wt_addr, 0);
        check("rst_data_wt", mif.data_wt, 0);
        check("rst_rd_addr", mif.rd_addr, 0);
        check("rst_ex_ready", ex_ready, 1);

        // store then load to the same address
        p = wr_pulses;
        drive(1'b1, 2'd3, 16'h0010, 16'hAAAA, 3'd0);
        tick();
        check("st_wt_en", mif.wt_en, 1);
        check("st_wt_addr", mif.wt_addr, 8'h10);
        check("st_data_wt", mif.data_wt, 16'hAAAA);
        drive(1'b1, 2'd2, 16'h0010, 16'h0000, 3'd2);
        tick();
        check("st_mem", mem[8'h10], 16'hAAAA);
        check("st_store_cnt", store_cnt, 1);
        check("st_wb_valid", wb_valid, 1);
        check("st_wb_we", wb_we, 0);
        check("ld_wt_en", mif.wt_en, 0);
        check("ld_rd_addr", mif.rd_addr, 8'h10);
        nop();
        tick();
        check("ld_wb_data", wb_data, 16'hAAAA);
        check("ld_wb_we", wb_we, 1);
        check("ld_wb_rd", wb_rd, 2);
        check("ld_load_cnt", load_cnt, 1);
        check("st_pulses", wr_pulses - p, 1);
        tick();
        check("bub_wb_valid", wb_valid, 0);
        check("bub_wb_we", wb_we, 0);
        check("bub_wb_rd", wb_rd, 2);
        check("bub_wb_data", wb_data, 16'hAAAA);

        // ALU then store, stalled for three cycles
        drive(1'b1, 2'd1, 16'h1234, 16'h0000, 3'd5);
        tick();
        drive(1'b1, 2'd3, 16'h0030, 16'h7777, 3'd0);
        tick();
        p = wr_pulses;
        check("stl_pre_wt_en", mif.wt_en, 1);
        wb_stall = 1'b1;
        drive(1'b1, 2'd1, 16'h00FF, 16'h0000, 3'd1);
        #1;
        check("stl_wt_en", mif.wt_en, 0);
        check("stl_ex_ready", ex_ready, 0);
        tick(); tick(); tick();
        check("stl_wb_valid", wb_valid, 1);
        check("stl_wb_we", wb_we, 1);
        check("stl_wb_rd", wb_rd, 5);
        check("stl_wb_data", wb_data, 16'h1234);
        check("stl_exm_addr", mif.rd_addr, 8'h30);
        check("stl_exm_data", mif.data_wt, 16'h7777);
        check("stl_store_cnt", store_cnt, 1);
        check("stl_no_write", wr_pulses - p, 0);
        wb_stall = 1'b0;
        nop();
        #1;
        check("rel_wt_en", mif.wt_en, 1);
        tick();
        check("rel_store_cnt", store_cnt, 2);
        check("rel_wb_we", wb_we, 0);
        check("rel_wb_rd", wb_rd, 0);
        tick();
        check("rel_pulses", wr_pulses - p, 1);
        check("rel_mem", mem[8'h30], 16'h7777);

        // out-of-range store and load
        drive(1'b1, 2'd3, 16'h0105, 16'hBEEF, 3'd0);
        tick();
        check("bad_wt_en", mif.wt_en, 0);
        drive(1'b1, 2'd1, 16'h0001, 16'h0000, 3'd1);
        tick();
        check("bad_fault", fault, 1);
        check("bad_store_cnt", store_cnt, 2);
        check("bad_wb_we", wb_we, 0);
        drive(1'b1, 2'd2, 16'h0200, 16'h0000, 3'd4);
        tick();
        check("bad_alu_we", wb_we, 1);
        nop();
        tick();
        check("badld_wb_valid", wb_valid, 1);
        check("badld_wb_we", wb_we, 0);
        check("badld_wb_data", wb_data, 0);
        check("badld_load_cnt", load_cnt, 1);
        check("bad_fault_sticky", fault, 1);
        check("bad_mem5", mem[8'h05], 0);

        // flush a store sitting in EX/MEM
        p = wr_pulses;
        drive(1'b1, 2'd3, 16'h0020, 16'h5555, 3'd0);
        tick();
        nop();
        flush = 1'b1;
        #1;
        check("fl_wt_en", mif.wt_en, 0);
        tick();
        flush = 1'b0;
        check("fl_wb_valid", wb_valid, 0);
        check("fl_wb_we", wb_we, 0);
        check("fl_store_cnt", store_cnt, 2);
        drive(1'b1, 2'd2, 16'h0020, 16'h0000, 3'd6);
        tick();
        drive(1'b1, 2'd3, 16'h0021, 16'h6666, 3'd0);
        tick();
        check("fl_ld_data", wb_data, 0);
        check("fl_ld_we", wb_we, 1);
        check("fl_ld_rd", wb_rd, 6);
        check("fl_load_cnt", load_cnt, 2);
        // flush and stall together: EX/MEM cleared, MEM/WB held
        nop();
        flush = 1'b1; wb_stall = 1'b1;
        tick();
        flush = 1'b0; wb_stall = 1'b0;
        check("fs_wb_valid", wb_valid, 1);
        check("fs_wb_rd", wb_rd, 6);
        tick();
        check("fs_bubble", wb_valid, 0);
        check("fs_mem21", mem[8'h21], 0);
        check("fs_pulses", wr_pulses - p, 0);
        check("fs_store_cnt", store_cnt, 2);

        // reset while a store sits in EX/MEM
        p = wr_pulses;
        drive(1'b1, 2'd3, 16'h0040, 16'h4444, 3'd3);
        tick();
        nop();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rs_mem40", mem[8'h40], 0);
        check("rs_pulses", wr_pulses - p, 0);
        check("rs_wt_en", mif.wt_en, 0);
        check("rs_wt_addr", mif.wt_addr, 0);
        check("rs_data_wt", mif.data_wt, 0);
        check("rs_wb_valid", wb_valid, 0);
        check("rs_wb_data", wb_data, 0);
        check("rs_wb_rd", wb_rd, 0);
        check("rs_fault", fault, 0);
        check("rs_load_cnt", load_cnt, 0);
        check("rs_store_cnt", store_cnt, 0);

        // store counter wrap
        drive(1'b1, 2'd3, 16'h0050, 16'h1111, 3'd0);
        for (int i = 0; i < 65535; i++) tick();
        nop();
        tick();
        check("wrap_full", store_cnt, 16'hFFFF);
        drive(1'b1, 2'd3, 16'h0050, 16'h2222, 3'd0);
        tick();
        nop();
        tick();
        check("wrap_zero", store_cnt, 16'h0000);
        check("wrap_load_cnt", load_cnt, 0);
        check("wrap_mem50", mem[8'h50], 16'h2222);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
